// File: rtl/tx_pulse_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hfswr_tx_pkg
// Brief    : Shared types and constants for the HFSWR transmit pulse scheduler.
// Revision : 1.0
// ============================================================================
package hfswr_tx_pkg;

    localparam int CODE_W       = 16;
    localparam int DEF_CHIP_DIV = 1229;
    localparam int DEF_CODE_LEN = 16;
    // One extra chip absorbs the code generator's latency before its first bit.
    localparam int CODE_WIN     = (DEF_CODE_LEN + 1) * DEF_CHIP_DIV;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_CODE = 3'd2,
        ST_POST = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    function automatic int code_win(input int chip_div, input int code_len);
        return (code_len + 1) * chip_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_pulse_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_pulse_scheduler_if
// Brief    : Configuration, control and pulse output bundle of the scheduler.
// Revision : 1.0
// ============================================================================
interface tx_pulse_scheduler_if #(
    parameter int NUM_CODES = 4,
    parameter int PRI_W     = 24
);
    import hfswr_tx_pkg::*;

    localparam int ADDR_W = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;

    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [CODE_W-1:0]   cfg_data;
    logic [PRI_W-1:0]    pri;
    logic [11:0]         guard;
    logic [15:0]         n_pulses;
    logic                start;
    logic                stop;
    logic                busy;
    logic                done;
    logic                err;
    logic                sinc;
    logic [CODE_W-1:0]   codigo;
    logic [ADDR_W-1:0]   code_idx;
    logic                tx_gate;
    logic [15:0]         pulse_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_data, pri, guard, n_pulses, start, stop,
        input  busy, done, err, sinc, codigo, code_idx, tx_gate, pulse_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, pri, guard, n_pulses, start, stop,
        output busy, done, err, sinc, codigo, code_idx, tx_gate, pulse_cnt
    );

endinterface
`default_nettype wire

// File: rtl/tx_pulse_scheduler_pri_timer.sv
`default_nettype none
// ============================================================================
// Module   : pri_timer
// Brief    : Loadable down-counter; o_expire marks the last cycle of the interval.
// Revision : 1.0
// ============================================================================
module pri_timer #(
    parameter int W = 24
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_value,
    output logic              o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = (r_cnt == W'(1));

endmodule
`default_nettype wire

// File: rtl/tx_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_pulse_scheduler
// Brief    : Pulse sequencer driving code generator enable, code word and T/R gate.
// Revision : 1.0
// ============================================================================
module tx_pulse_scheduler
    import hfswr_tx_pkg::*;
#(
    parameter int CHIP_DIV  = DEF_CHIP_DIV,
    parameter int CODE_LEN  = DEF_CODE_LEN,
    parameter int NUM_CODES = 4,
    parameter int PRI_W     = 24
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tx_pulse_scheduler_if.slave sched
);

    localparam int WIN    = code_win(CHIP_DIV, CODE_LEN);
    localparam int ADDR_W = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
    localparam int PH_W   = ($clog2(WIN) > 12) ? $clog2(WIN) : 12;

    state_t              r_state, w_state_nxt, w_first;
    logic [PH_W-1:0]     r_phase;
    logic [PRI_W-1:0]    r_pri, w_pri_load;
    logic [11:0]         r_guard;
    logic [15:0]         r_npulses, r_pulse_cnt;
    logic                r_err, r_stop_lat, r_busy, r_done, r_sinc, r_tx_gate;
    logic [CODE_W-1:0]   r_codigo, w_load_word;
    logic [ADDR_W-1:0]   r_code_idx, w_load_idx;
    logic [CODE_W-1:0]   r_bank [NUM_CODES];
    logic                w_bad, w_accept, w_reject, w_load, w_pulse_end, w_last, w_expire;
    logic                w_guard_last, w_code_last, w_cfg_wr;

    // Bank has no reset so configured codes survive a system reset.
    assign w_cfg_wr = sched.cfg_we && (r_state == ST_IDLE);
    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_bank[sched.cfg_addr] <= sched.cfg_data;
        end
    end

    assign w_bad        = (32'(sched.pri) < ((32'(sched.guard) << 1) + 32'(WIN)));
    assign w_guard_last = (r_phase == (PH_W'(r_guard) - PH_W'(1)));
    assign w_code_last  = (r_phase == PH_W'(WIN - 1));
    assign w_last       = r_stop_lat || sched.stop ||
                          ((r_npulses != 16'd0) && ((r_pulse_cnt + 16'd1) == r_npulses));
    assign w_first      = (r_guard == 12'd0) ? ST_CODE : ST_PRE;
    assign w_pri_load   = (r_state == ST_IDLE) ? sched.pri : r_pri;
    // A same-cycle write in IDLE must reach the first pulse's code word.
    assign w_load_word  = (w_cfg_wr && (sched.cfg_addr == w_load_idx)) ? sched.cfg_data
                                                                       : r_bank[w_load_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_load      = 1'b0;
        w_pulse_end = 1'b0;
        w_load_idx  = r_code_idx;
        case (r_state)
            ST_IDLE: begin
                if (sched.start) begin
                    if (w_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_load      = 1'b1;
                        w_load_idx  = '0;
                        w_state_nxt = (sched.guard == 12'd0) ? ST_CODE : ST_PRE;
                    end
                end
            end
            ST_PRE:  if (w_guard_last) w_state_nxt = ST_CODE;
            ST_CODE: begin
                if (w_code_last) begin
                    if (r_guard == 12'd0) w_pulse_end = 1'b1;
                    else                  w_state_nxt = ST_POST;
                end
            end
            ST_POST: if (w_guard_last) w_pulse_end = 1'b1;
            ST_WAIT: begin
                if (w_expire) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_first;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // An exactly-filled PRI goes straight into the next pulse without WAIT.
        if (w_pulse_end) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
            end else if (w_expire) begin
                w_load      = 1'b1;
                w_load_idx  = r_code_idx + ADDR_W'(1);
                w_state_nxt = w_first;
            end else begin
                w_state_nxt = ST_WAIT;
            end
        end
    end

    pri_timer #(.W(PRI_W)) u_pri_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_value  (w_pri_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_pri       <= '0;
            r_guard     <= '0;
            r_npulses   <= '0;
            r_err       <= 1'b0;
            r_stop_lat  <= 1'b0;
            r_pulse_cnt <= '0;
            r_code_idx  <= '0;
            r_codigo    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sinc      <= 1'b0;
            r_tx_gate   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= ((w_state_nxt != r_state) || w_load) ? '0 : r_phase + PH_W'(1);
            if (w_accept) begin
                r_pri     <= sched.pri;
                r_guard   <= sched.guard;
                r_npulses <= sched.n_pulses;
            end
            if (w_reject)      r_err <= 1'b1;
            else if (w_accept) r_err <= 1'b0;
            if (w_state_nxt == ST_IDLE)                 r_stop_lat <= 1'b0;
            else if (r_state != ST_IDLE && sched.stop)  r_stop_lat <= 1'b1;
            if (w_accept) begin
                r_pulse_cnt <= '0;
                r_code_idx  <= '0;
            end else if (w_pulse_end) begin
                r_pulse_cnt <= r_pulse_cnt + 16'd1;
                r_code_idx  <= r_code_idx + ADDR_W'(1);
            end
            if (w_load) r_codigo <= w_load_word;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
            r_sinc    <= (w_state_nxt == ST_CODE);
            r_tx_gate <= (w_state_nxt == ST_PRE) || (w_state_nxt == ST_CODE) ||
                         (w_state_nxt == ST_POST);
        end
    end

    assign sched.busy      = r_busy;
    assign sched.done      = r_done;
    assign sched.err       = r_err;
    assign sched.sinc      = r_sinc;
    assign sched.codigo    = r_codigo;
    assign sched.code_idx  = r_code_idx;
    assign sched.tx_gate   = r_tx_gate;
    assign sched.pulse_cnt = r_pulse_cnt;

endmodule
`default_nettype wire
